// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared RV32M op codes, FSM state type and divide constants
// for the muldiv_unit execute block.
package muldiv_pkg;

   localparam logic [4:0] OP_MULHU  = 5'b01000;
   localparam logic [4:0] OP_MUL    = 5'b01001;
   localparam logic [4:0] OP_MULHSU = 5'b01010;
   localparam logic [4:0] OP_MULH   = 5'b01011;
   localparam logic [4:0] OP_DIVU   = 5'b01100;
   localparam logic [4:0] OP_DIV    = 5'b01101;
   localparam logic [4:0] OP_REMU   = 5'b01110;
   localparam logic [4:0] OP_REM    = 5'b01111;

   localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN    = 32'h8000_0000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX,
      S_DONE
   } state_t;

endpackage

// File: rtl/muldiv_div_core.sv
// muldiv_div_core: unsigned radix-2 restoring divider, one quotient bit
// per cycle; done flags the cycle whose edge retires the last iteration.
module muldiv_div_core #(
   parameter int XLEN  = 32,
   parameter int ITERS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder,
   output logic            done
);

   localparam int CW = $clog2(ITERS);

   logic [XLEN-1:0] dvs;
   logic [CW-1:0]   cnt;
   logic            running;
   logic [XLEN:0]   shifted;
   logic [XLEN:0]   diff;

   // Trial subtraction of the divisor from the shifted partial remainder
   always_comb begin
      shifted = {remainder, quotient[XLEN-1]};
      diff    = shifted - {1'b0, dvs};
   end

   assign done = running && (cnt == '0);

   // Load on start, then shift in one quotient bit per cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         running <= 1'b0;
      end else if (start) begin
         quotient  <= dividend;
         remainder <= '0;
         dvs       <= divisor;
         cnt       <= CW'(ITERS - 1);
         running   <= 1'b1;
      end else if (running) begin
         if (diff[XLEN]) begin
            remainder <= shifted[XLEN-1:0];
            quotient  <= {quotient[XLEN-2:0], 1'b0};
         end else begin
            remainder <= diff[XLEN-1:0];
            quotient  <= {quotient[XLEN-2:0], 1'b1};
         end
         cnt <= cnt - CW'(1);
         if (cnt == '0) running <= 1'b0;
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M execute unit (2-cycle MUL, 34-cycle DIV).
// Define MULDIV_EARLY_OUT_EN to retire divide-by-zero/overflow in 1 cycle.
module muldiv_unit #(
   parameter int XLEN      = 32,
   parameter int DIV_ITERS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      alu_control,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            illegal_op,
   output logic            busy
);

   import muldiv_pkg::*;

   state_t            state;
   logic [1:0]        op_reg;
   logic [XLEN-1:0]   a_reg;
   logic [XLEN-1:0]   b_reg;
   logic              q_neg;
   logic              r_neg;
   logic              div_zero;

   logic              accept;
   logic              legal;
   logic              is_div;
   logic              a_neg_in;
   logic              b_neg_in;
   logic [XLEN-1:0]   mag_a;
   logic [XLEN-1:0]   mag_b;
   logic              start;
   logic              early;
   logic [XLEN-1:0]   early_word;
   logic [2*XLEN-1:0] wa;
   logic [2*XLEN-1:0] wb;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   mul_word;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   q_fix;
   logic [XLEN-1:0]   r_fix;
   logic [XLEN-1:0]   fix_word;
   logic              div_done;

   assign in_ready = (state == S_IDLE) && !rst;
   assign busy     = (state != S_IDLE);
   assign accept   = in_valid && in_ready;

   // Accept-side decode and operand magnitudes for the divider
   always_comb begin
      legal    = (alu_control[4:3] == 2'b01);
      is_div   = alu_control[2];
      a_neg_in = alu_control[0] && operand_a[XLEN-1];
      b_neg_in = alu_control[0] && operand_b[XLEN-1];
      mag_a    = a_neg_in ? -operand_a : operand_a;
      mag_b    = b_neg_in ? -operand_b : operand_b;
   end

`ifdef MULDIV_EARLY_OUT_EN
   logic b_zero_in;
   logic ovf_in;

   // Special divide results resolved at accept time
   always_comb begin
      b_zero_in = (operand_b == '0);
      ovf_in    = alu_control[0] && (operand_a == INT_MIN)
                  && (operand_b == '1);
      early     = is_div && (b_zero_in || ovf_in);
      if (b_zero_in)
         early_word = alu_control[1] ? operand_a : DIV_ZERO_Q;
      else
         early_word = alu_control[1] ? '0 : INT_MIN;
   end
`else
   assign early      = 1'b0;
   assign early_word = '0;
`endif

   assign start = accept && legal && is_div && !early;

   muldiv_div_core #(
      .XLEN  (XLEN),
      .ITERS (DIV_ITERS)
   ) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (mag_a),
      .divisor   (mag_b),
      .quotient  (quo),
      .remainder (rem),
      .done      (div_done)
   );

   // Signed/unsigned widening product and word select
   always_comb begin
      wa       = {{XLEN{op_reg[1] && a_reg[XLEN-1]}}, a_reg};
      wb       = {{XLEN{(&op_reg) && b_reg[XLEN-1]}}, b_reg};
      prod     = wa * wb;
      mul_word = (op_reg == 2'b01) ? prod[XLEN-1:0]
                                   : prod[2*XLEN-1:XLEN];
   end

   // Sign fix-up of the unsigned divider outputs
   always_comb begin
      q_fix    = div_zero ? DIV_ZERO_Q : (q_neg ? -quo : quo);
      r_fix    = r_neg ? -rem : rem;
      fix_word = op_reg[1] ? r_fix : q_fix;
   end

   // Control FSM with registered result/illegal_op/out_valid
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         out_valid  <= 1'b0;
         result     <= '0;
         illegal_op <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: if (accept) begin
               op_reg   <= alu_control[1:0];
               a_reg    <= operand_a;
               b_reg    <= operand_b;
               q_neg    <= a_neg_in ^ b_neg_in;
               r_neg    <= a_neg_in;
               div_zero <= (operand_b == '0);
               if (!legal) begin
                  state      <= S_DONE;
                  result     <= '0;
                  illegal_op <= 1'b1;
                  out_valid  <= 1'b1;
               end else if (!is_div) begin
                  state <= S_MUL;
               end else if (early) begin
                  state      <= S_DONE;
                  result     <= early_word;
                  illegal_op <= 1'b0;
                  out_valid  <= 1'b1;
               end else begin
                  state <= S_DIV;
               end
            end
            S_MUL: begin
               result     <= mul_word;
               illegal_op <= 1'b0;
               out_valid  <= 1'b1;
               state      <= S_DONE;
            end
            S_DIV: if (div_done) state <= S_FIX;
            S_FIX: begin
               result     <= fix_word;
               illegal_op <= 1'b0;
               out_valid  <= 1'b1;
               state      <= S_DONE;
            end
            S_DONE: if (out_ready) begin
               out_valid <= 1'b0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed scoreboard bench for muldiv_unit covering
// MUL/DIV results, latencies, backpressure, illegal codes and reset abort.
module tb_muldiv_unit;

   import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
   localparam int SP_LAT = 1;
`else
   localparam int SP_LAT = 34;
`endif

   typedef struct {
      string       tag;
      logic [31:0] res;
      logic        ill;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  alu_control;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        illegal_op;
   logic        busy;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   muldiv_unit dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .alu_control (alu_control),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .illegal_op  (illegal_op),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res,
                       input logic ill, input int lat,
                       input string tag, input bit push);
      exp_t e;
      @(negedge clk);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      in_valid    = 1'b1;
      alu_control = op;
      operand_a   = a;
      operand_b   = b;
      if (push) begin
         e.tag = tag;
         e.res = res;
         e.ill = ill;
         e.lat = lat;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid    = 1'b0;
      alu_control = 5'($urandom);
      operand_a   = $urandom;
      operand_b   = $urandom;
   endtask

   task automatic collect(input int hold);
      exp_t e;
      int   n;
      bit   seen;
      if (sb.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL scoreboard_empty: got 0 entries, expected 1");
         return;
      end
      e    = sb.pop_front();
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 60) begin
         @(negedge clk);
         n++;
         seen = out_valid;
      end
      chk({e.tag, "_latency"}, 32'(n), 32'(e.lat));
      chk({e.tag, "_result"}, result, e.res);
      chk({e.tag, "_illegal"}, 32'(illegal_op), 32'(e.ill));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({e.tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         chk({e.tag, "_hold_result"}, result, e.res);
         chk({e.tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk({e.tag, "_drop_valid"}, 32'(out_valid), 32'd0);
      chk({e.tag, "_next_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      rst         = 1'b1;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      alu_control = '0;
      operand_a   = '0;
      operand_b   = '0;

      repeat (3) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_illegal", 32'(illegal_op), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      out_ready = 1'b1;
      send(OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000,
           1'b0, 2, "mulh", 1'b1);
      collect(0);
      send(OP_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB,
           1'b0, 2, "mul", 1'b1);
      collect(0);
      send(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
           1'b0, 2, "mulhu", 1'b1);
      collect(0);
      send(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           1'b0, 2, "mulhsu", 1'b1);
      collect(0);

      send(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD,
           1'b0, 34, "div", 1'b1);
      collect(0);
      send(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF,
           1'b0, 34, "rem", 1'b1);
      collect(0);
      send(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 34, "divu", 1'b1);
      collect(0);
      send(OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 34, "remu", 1'b1);
      collect(0);

      send(OP_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF,
           1'b0, SP_LAT, "divu_z", 1'b1);
      collect(0);
      send(OP_REMU, 32'd7, 32'd0, 32'd7, 1'b0, SP_LAT, "remu_z", 1'b1);
      collect(0);
      send(OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF,
           1'b0, SP_LAT, "div_z", 1'b1);
      collect(0);
      send(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
           1'b0, SP_LAT, "div_ovf", 1'b1);
      collect(0);
      send(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,
           1'b0, SP_LAT, "rem_ovf", 1'b1);
      collect(0);

      for (int i = 0; i < 3; i++) begin
         ra = $urandom;
         rb = 32'($urandom_range(1, 1000));
         send(OP_DIVU, ra, rb, ra / rb, 1'b0, 34, "divu_r", 1'b1);
         collect(0);
         send(OP_REMU, ra, rb, ra % rb, 1'b0, 34, "remu_r", 1'b1);
         collect(0);
         send(OP_MUL, ra, rb, ra * rb, 1'b0, 2, "mul_r", 1'b1);
         collect(0);
      end

      send(OP_MUL, 32'd6, 32'd9, 32'd54, 1'b0, 2, "bp_mul", 1'b1);
      collect(10);

      send(5'b10010, 32'd5, 32'd6, 32'd0, 1'b1, 1, "illegal", 1'b1);
      collect(0);

      send(OP_DIV, 32'd1000, 32'd3, 32'd0, 1'b0, 0, "abort", 1'b0);
      repeat (15) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_in_ready_rst", 32'(in_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      send(OP_MUL, 32'd3, 32'd5, 32'd15, 1'b0, 2, "mul_after", 1'b1);
      collect(0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
